// File: rtl/nios_pio_gen.sv
// Avalon-MM parallel I/O slave: per-bit direction, atomic set/clear, synchronised inputs,
// edge capture and maskable irq. Define NIOS_PIO_BITCLR_EN for write-1-to-clear edge capture.
module nios_pio_gen #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] DIR_RESET = 32'h0,
   parameter logic [31:0] OUT_RESET = 32'h0,
   parameter int          EDGE_TYPE = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe_port,
   output logic             irq
);

   logic             wr_en;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] dir;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] prev_in;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] ec_clr;
   logic [31:0]      rd_mux;
   logic             unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   generate
      if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~sync_in & prev_in;
      end else if (EDGE_TYPE == 2) begin : g_any
         assign edge_det = sync_in ^ prev_in;
      end else begin : g_rise
         assign edge_det = sync_in & ~prev_in;
      end
   endgenerate

`ifdef NIOS_PIO_BITCLR_EN
   assign ec_clr = (wr_en && address == 3'd3) ? wd : '0;
`else
   assign ec_clr = {WIDTH{wr_en && address == 3'd3}};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= OUT_RESET[WIDTH-1:0];
         dir      <= DIR_RESET[WIDTH-1:0];
         irq_mask <= '0;
      end else if (wr_en) begin
         case (address)
            3'd0:    data_out <= wd;
            3'd1:    dir      <= wd;
            3'd2:    irq_mask <= wd;
            3'd4:    data_out <= data_out | wd;
            3'd5:    data_out <= data_out & ~wd;
            default: ;
         endcase
      end
   end

   // Two-flop synchroniser, then one delay stage for edge comparison
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_in   <= '0;
         prev_in   <= '0;
      end else begin
         sync_meta <= in_port;
         sync_in   <= sync_meta;
         prev_in   <= sync_in;
      end
   end

   // A new edge overrides a simultaneous clear on the same bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         edge_capture <= (edge_capture & ~ec_clr) | edge_det;
         irq          <= |(edge_capture & irq_mask);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0:    rd_mux[WIDTH-1:0] = (sync_in & ~dir) | (data_out & dir);
         3'd1:    rd_mux[WIDTH-1:0] = dir;
         3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
         3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

   assign out_port = data_out;
   assign oe_port  = dir;

endmodule

// File: doc/nios_pio_gen.md
Name: nios_pio_gen

Overview:
Parametrised Avalon-MM parallel I/O slave. It generalises the fixed 3-bit command PIO to N bits, with per-bit direction, atomic set/clear of outputs, synchronised inputs, edge capture and a maskable interrupt to the Nios II. It sits on the system interconnect between the CPU data master and board-level GPIO/command lines.

Parameters:
WIDTH, 8, number of I/O bits (1..32)
DIR_RESET, 0, reset value of the direction register (bit=1 -> output)
OUT_RESET, 0, reset value of the output data register
EDGE_TYPE, 0, edge detection mode: 0=rising, 1=falling, 2=any

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address of register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  external inputs (asynchronous to clk)
out_port  out  WIDTH  output data register
oe_port  out  WIDTH  per-bit output enable (= direction register)
irq  out  1  interrupt request, active high

Behaviour:
- Single clock domain clk; reset_n asynchronous assert, all state cleared immediately on assertion.
- Reset values: out_port=OUT_RESET, oe_port=DIR_RESET, irq_mask=0, edge_capture=0, sync flops=0, readdata=0, irq=0.
- Write = chipselect & ~write_n; takes effect on the next rising clk edge. Only writedata[WIDTH-1:0] is used; upper bits are ignored.
- Register map (address):
  - 0 DATA: read returns (sync_in & ~dir) | (data_out & dir); write loads data_out.
  - 1 DIRECTION: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAPTURE: read; write clears (see Optional Feature).
  - 4 OUTSET: write data_out |= wd; read returns 0.
  - 5 OUTCLEAR: write data_out &= ~wd; read returns 0.
  - 6, 7: reserved; read 0, writes ignored.
- readdata is registered every clk (clk_en=1), independent of chipselect. Read latency is 1 cycle. Bits above WIDTH read 0.
- Input path: in_port passes through a 2-flop synchroniser into sync_in, then one more flop into prev_in.
- Edge detect per bit:
  - rising = sync_in & ~prev_in
  - falling = ~sync_in & prev_in
  - any = XOR of the two
- A detected edge sets the matching edge_capture bit. Capture occurs on the 3rd rising clk edge after an in_port transition that meets setup.
- Edges are captured on all bits regardless of direction or irq_mask.
- Simultaneous edge and clear on the same bit: the set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask), driven from a flop and updated one cycle after edge_capture/irq_mask change. irq stays level-held until cleared.
- Pulses narrower than one clk period may be missed; this is not an error.
- Reset asserted mid-write: the write is lost and registers return to reset values.

Optional Feature:
Macro NIOS_PIO_BITCLR_EN.
- Defined: a write to EDGECAPTURE clears only the bits where writedata=1 (write-1-to-clear).
- Undefined: any write to EDGECAPTURE clears all bits regardless of data.
- In both builds, the set-over-clear priority holds.

Test Plan:
- Reset: assert reset_n=0 mid-sim -> out_port=OUT_RESET, oe_port=DIR_RESET, irq=0, readdata=0 immediately; read addr1 after release -> DIR_RESET.
- Data/dir mix (WIDTH=8): write DIRECTION=0x0F, DATA=0xA5, drive in_port=0x3C; read addr0 -> 0x35 one cycle after the read cycle.
- Set/clear: DATA=0x00, write OUTSET=0x81 -> out_port=0x81; write OUTCLEAR=0x01 -> out_port=0x80; read addr4 -> 0.
- Edge + irq (EDGE_TYPE=0): IRQMASK=0x04, in_port[2] 0->1 -> edge_capture=0x04 on 3rd clk edge, irq=1 the next cycle; in_port[3] rising with mask bit clear -> captured, irq unaffected.
- Clear: edge_capture=0x0C. With NIOS_PIO_BITCLR_EN, write 0x04 -> 0x08. Without it, write 0x04 -> 0x00. Clear coinciding with a new edge on bit 2 -> bit 2 stays 1.
- Falling/any: EDGE_TYPE=1, 1->0 sets the bit and 0->1 does not; EDGE_TYPE=2, both transitions set the bit.
